// File: rtl/spi_pkg.sv
// ============================================================================
// Module  : spi_pkg
// Brief   : Shared constants and state encoding for the SPI slave.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package spi_pkg;
  localparam int         SPI_BITS          = 8;
  localparam int         CNT_W             = $clog2(SPI_BITS);
  localparam logic [7:0] DEFAULT_IDLE_FILL = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } spi_state_t;
endpackage

`default_nettype wire

// File: rtl/spi_input_sync.sv
// ============================================================================
// Module  : spi_input_sync
// Brief   : Multi-flop synchronizer for one pin with rise/fall edge detect.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module spi_input_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_chain <= {STAGES{RESET_VAL}};
      r_prev  <= RESET_VAL;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], din};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign sync = r_chain[STAGES-1];
  assign rise = r_chain[STAGES-1] & ~r_prev;
  assign fall = ~r_chain[STAGES-1] & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_slave_module.sv
// ============================================================================
// Module  : spi_slave_module
// Brief   : Mode-3 SPI slave, oversampled on CLK, single-byte Tx/Rx buffers.
//           Define SPI_SLAVE_OVERRUN_EN to enable the sticky Rx_Overrun flag.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module spi_slave_module
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = DEFAULT_IDLE_FILL
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       SPI_CS,
  input  logic       SPI_SCK,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       SPI_MISO_En,
  input  logic [7:0] Tx_Data,
  input  logic       Tx_Load,
  output logic       Tx_Ready,
  output logic [7:0] Rx_Data,
  output logic       Rx_Valid,
  input  logic       Rx_Ack,
  output logic       Rx_Overrun
);

  localparam int c_sync_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_sck_sync, w_sck_rise, w_sck_fall;
  logic [c_sync_stages-1:0] r_mosi_chain;
  logic w_mosi;

  spi_input_sync #(.STAGES(c_sync_stages), .RESET_VAL(1'b1)) u_cs_sync (
    .CLK(CLK), .RSTn(RSTn), .din(SPI_CS),
    .sync(w_cs_sync), .rise(w_cs_rise), .fall(w_cs_fall)
  );

  spi_input_sync #(.STAGES(c_sync_stages), .RESET_VAL(1'b1)) u_sck_sync (
    .CLK(CLK), .RSTn(RSTn), .din(SPI_SCK),
    .sync(w_sck_sync), .rise(w_sck_rise), .fall(w_sck_fall)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_mosi_chain <= '0;
    else       r_mosi_chain <= {r_mosi_chain[c_sync_stages-2:0], SPI_MOSI};
  end
  assign w_mosi = r_mosi_chain[c_sync_stages-1];

  spi_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_wrap;
  logic [7:0]       r_tx_shift;
  logic [6:0]       r_rx_shift;
  logic [7:0]       r_tx_buf;
  logic             r_tx_full;
  logic [7:0]       r_rx_data;
  logic             r_rx_valid;

  logic w_start, w_abort, w_rise, w_fall, w_reload, w_shift, w_done, w_consume;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_cs_fall) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_cs_rise) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // The first SCK fall of a frame precedes any sample, so it keeps bit 7;
  // a fall after a completed byte reloads for the next back-to-back byte.
  assign w_start   = (r_state == ST_IDLE) && w_cs_fall;
  assign w_abort   = (r_state == ST_SHIFT) && w_cs_rise;
  assign w_rise    = (r_state == ST_SHIFT) && w_sck_rise && !w_cs_rise;
  assign w_fall    = (r_state == ST_SHIFT) && w_sck_fall && !w_sck_sync && !w_cs_rise;
  assign w_reload  = w_start || (w_fall && r_wrap);
  assign w_shift   = w_fall && !r_wrap && (r_bit_cnt != '0);
  assign w_done    = w_rise && (r_bit_cnt == CNT_W'(SPI_BITS - 1));
  assign w_consume = w_reload && r_tx_full;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_bit_cnt  <= '0;
      r_wrap     <= 1'b0;
      r_tx_shift <= 8'hFF;
      r_rx_shift <= '0;
    end else begin
      if (w_start || w_abort) begin
        r_bit_cnt <= '0;
        r_wrap    <= 1'b0;
      end else if (w_rise) begin
        r_bit_cnt  <= r_bit_cnt + 1'b1;
        r_rx_shift <= {r_rx_shift[5:0], w_mosi};
        r_wrap     <= w_done;
      end else if (w_fall) begin
        r_wrap <= 1'b0;
      end

      if (w_reload)     r_tx_shift <= r_tx_full ? r_tx_buf : IDLE_FILL;
      else if (w_shift) r_tx_shift <= {r_tx_shift[6:0], 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_tx_buf  <= '0;
      r_tx_full <= 1'b0;
    end else if (w_consume) begin
      r_tx_full <= 1'b0;
    end else if (Tx_Load && !r_tx_full) begin
      r_tx_buf  <= Tx_Data;
      r_tx_full <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (w_done) r_rx_data <= {r_rx_shift, w_mosi};
      if (w_done)      r_rx_valid <= 1'b1;
      else if (Rx_Ack) r_rx_valid <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic r_overrun;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                                r_overrun <= 1'b0;
    else if (w_done && r_rx_valid && !Rx_Ack) r_overrun <= 1'b1;
    else if (Rx_Ack)                          r_overrun <= 1'b0;
  end
  assign Rx_Overrun = r_overrun;
`else
  assign Rx_Overrun = 1'b0;
`endif

  assign SPI_MISO    = (r_state == ST_SHIFT) ? r_tx_shift[7] : 1'b1;
  assign SPI_MISO_En = ~w_cs_sync;
  assign Tx_Ready    = ~r_tx_full;
  assign Rx_Data     = r_rx_data;
  assign Rx_Valid    = r_rx_valid;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_module.sv
// ============================================================================
// Module  : tb_spi_slave_module
// Brief   : Directed mode-3 master bench for spi_slave_module (SCK = CLK/8).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave_module;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       SPI_CS, SPI_SCK, SPI_MOSI;
  logic       SPI_MISO, SPI_MISO_En;
  logic [7:0] Tx_Data;
  logic       Tx_Load;
  logic       Tx_Ready;
  logic [7:0] Rx_Data;
  logic       Rx_Valid;
  logic       Rx_Ack;
  logic       Rx_Overrun;

  int checks = 0;
  int errors = 0;

`ifdef SPI_SLAVE_OVERRUN_EN
  localparam logic c_ovr_exp = 1'b1;
`else
  localparam logic c_ovr_exp = 1'b0;
`endif

  spi_slave_module #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .SPI_CS(SPI_CS), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .SPI_MISO_En(SPI_MISO_En),
    .Tx_Data(Tx_Data), .Tx_Load(Tx_Load), .Tx_Ready(Tx_Ready),
    .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid), .Rx_Ack(Rx_Ack),
    .Rx_Overrun(Rx_Overrun)
  );

  always #5 CLK = ~CLK;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load_tx(input logic [7:0] d);
    Tx_Data = d; Tx_Load = 1'b1;
    wait_clk(1);
    Tx_Load = 1'b0;
    wait_clk(1);
  endtask

  task automatic ack_rx();
    Rx_Ack = 1'b1;
    wait_clk(1);
    Rx_Ack = 1'b0;
    wait_clk(1);
  endtask

  task automatic cs_low();
    SPI_CS = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    SPI_CS = 1'b1;
    wait_clk(4);
  endtask

  // Master drives MOSI on SCK fall and samples MISO just before SCK rise.
  task automatic spi_bits(input int n, input logic [7:0] mo, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      SPI_SCK = 1'b0; SPI_MOSI = mo[i];
      wait_clk(4);
      mi[i] = SPI_MISO;
      SPI_SCK = 1'b1;
      wait_clk(4);
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0; SPI_CS = 1'b1; SPI_SCK = 1'b1; SPI_MOSI = 1'b0;
    Tx_Data = 8'h00; Tx_Load = 1'b0; Rx_Ack = 1'b0;
    wait_clk(3);
    checks++; if (SPI_MISO !== 1'b1)    begin errors++; $display("FAIL reset_miso got %b want 1", SPI_MISO); end
    checks++; if (SPI_MISO_En !== 1'b0) begin errors++; $display("FAIL reset_miso_en got %b want 0", SPI_MISO_En); end
    checks++; if (Tx_Ready !== 1'b1)    begin errors++; $display("FAIL reset_tx_ready got %b want 1", Tx_Ready); end
    checks++; if (Rx_Data !== 8'h00)    begin errors++; $display("FAIL reset_rx_data got %h want 00", Rx_Data); end
    checks++; if (Rx_Valid !== 1'b0)    begin errors++; $display("FAIL reset_rx_valid got %b want 0", Rx_Valid); end
    checks++; if (Rx_Overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun got %b want 0", Rx_Overrun); end
    RSTn = 1'b1;
    wait_clk(2);
  endtask

  task automatic test_basic();
    logic [7:0] mi;
    load_tx(8'hA5);
    checks++; if (Tx_Ready !== 1'b0) begin errors++; $display("FAIL basic_tx_full got %b want 0", Tx_Ready); end
    cs_low();
    checks++; if (SPI_MISO_En !== 1'b1) begin errors++; $display("FAIL basic_miso_en got %b want 1", SPI_MISO_En); end
    checks++; if (Tx_Ready !== 1'b1) begin errors++; $display("FAIL basic_tx_consumed got %b want 1", Tx_Ready); end
    spi_bits(8, 8'h3C, mi);
    checks++; if (mi !== 8'hA5)       begin errors++; $display("FAIL basic_miso got %h want a5", mi); end
    checks++; if (Rx_Data !== 8'h3C)  begin errors++; $display("FAIL basic_rx_data got %h want 3c", Rx_Data); end
    checks++; if (Rx_Valid !== 1'b1)  begin errors++; $display("FAIL basic_rx_valid got %b want 1", Rx_Valid); end
    cs_high();
    checks++; if (SPI_MISO_En !== 1'b0 || SPI_MISO !== 1'b1) begin
      errors++; $display("FAIL basic_idle_pins got en=%b miso=%b want en=0 miso=1", SPI_MISO_En, SPI_MISO);
    end
    ack_rx();
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL basic_ack got %b want 0", Rx_Valid); end
  endtask

  task automatic test_idle_fill();
    logic [7:0] mi;
    cs_low();
    spi_bits(8, 8'h96, mi);
    checks++; if (mi !== 8'hFF)      begin errors++; $display("FAIL fill_miso got %h want ff", mi); end
    checks++; if (Tx_Ready !== 1'b1) begin errors++; $display("FAIL fill_tx_ready got %b want 1", Tx_Ready); end
    checks++; if (Rx_Data !== 8'h96) begin errors++; $display("FAIL fill_rx_data got %h want 96", Rx_Data); end
    cs_high();
    ack_rx();
  endtask

  task automatic test_load_ignored();
    logic [7:0] mi;
    load_tx(8'h12);
    load_tx(8'h34);
    cs_low();
    spi_bits(8, 8'h00, mi);
    checks++; if (mi !== 8'h12) begin errors++; $display("FAIL ignore_miso got %h want 12", mi); end
    cs_high();
    ack_rx();
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi;
    load_tx(8'h11);
    cs_low();
    load_tx(8'h22);
    spi_bits(8, 8'h01, mi);
    checks++; if (mi !== 8'h11)      begin errors++; $display("FAIL b2b_miso0 got %h want 11", mi); end
    checks++; if (Rx_Data !== 8'h01 || Rx_Valid !== 1'b1) begin
      errors++; $display("FAIL b2b_rx0 got %h/%b want 01/1", Rx_Data, Rx_Valid);
    end
    ack_rx();
    spi_bits(8, 8'h02, mi);
    checks++; if (mi !== 8'h22)      begin errors++; $display("FAIL b2b_miso1 got %h want 22", mi); end
    checks++; if (Rx_Data !== 8'h02 || Rx_Valid !== 1'b1) begin
      errors++; $display("FAIL b2b_rx1 got %h/%b want 02/1", Rx_Data, Rx_Valid);
    end
    checks++; if (Tx_Ready !== 1'b1) begin errors++; $display("FAIL b2b_tx_ready got %b want 1", Tx_Ready); end
    cs_high();
    ack_rx();
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    cs_low();
    spi_bits(5, 8'hF0, mi);
    cs_high();
    checks++; if (Rx_Valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", Rx_Valid); end
    checks++; if (Rx_Data !== 8'h02) begin errors++; $display("FAIL abort_data got %h want 02", Rx_Data); end
    cs_low();
    spi_bits(8, 8'h5A, mi);
    checks++; if (Rx_Data !== 8'h5A || Rx_Valid !== 1'b1) begin
      errors++; $display("FAIL abort_next got %h/%b want 5a/1", Rx_Data, Rx_Valid);
    end
    cs_high();
    ack_rx();
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    cs_low();
    spi_bits(8, 8'hAA, mi);
    spi_bits(8, 8'h55, mi);
    cs_high();
    checks++; if (Rx_Data !== 8'h55)        begin errors++; $display("FAIL ovr_data got %h want 55", Rx_Data); end
    checks++; if (Rx_Overrun !== c_ovr_exp) begin errors++; $display("FAIL ovr_flag got %b want %b", Rx_Overrun, c_ovr_exp); end
    ack_rx();
    checks++; if (Rx_Valid !== 1'b0 || Rx_Overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_ack got valid=%b ovr=%b want 0/0", Rx_Valid, Rx_Overrun);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    cs_low();
    load_tx(8'h5F);
    spi_bits(3, 8'hC3, mi);
    SPI_SCK = 1'b0; SPI_MOSI = 1'b0;
    wait_clk(2);
    RSTn = 1'b0;
    wait_clk(1);
    checks++; if (SPI_MISO !== 1'b1 || SPI_MISO_En !== 1'b0) begin
      errors++; $display("FAIL rstmid_pins got miso=%b en=%b want 1/0", SPI_MISO, SPI_MISO_En);
    end
    checks++; if (Tx_Ready !== 1'b1)   begin errors++; $display("FAIL rstmid_tx_ready got %b want 1", Tx_Ready); end
    checks++; if (Rx_Data !== 8'h00 || Rx_Valid !== 1'b0 || Rx_Overrun !== 1'b0) begin
      errors++; $display("FAIL rstmid_rx got %h/%b/%b want 00/0/0", Rx_Data, Rx_Valid, Rx_Overrun);
    end
    SPI_CS = 1'b1; SPI_SCK = 1'b1;
    wait_clk(3);
    RSTn = 1'b1;
    wait_clk(4);
    cs_low();
    spi_bits(8, 8'hC3, mi);
    checks++; if (mi !== 8'hFF) begin errors++; $display("FAIL rstmid_miso got %h want ff", mi); end
    checks++; if (Rx_Data !== 8'hC3 || Rx_Valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_rx_after got %h/%b want c3/1", Rx_Data, Rx_Valid);
    end
    cs_high();
    ack_rx();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_fill();
    test_load_ignored();
    test_back_to_back();
    test_abort();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_slave_module.md
SPI_SLAVE_MODULE -- requirements
Module: spi_slave_module

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for SPI pins (min 2).
REQ-002 SHALL have parameter IDLE_FILL, default 8'hFF, byte shifted out when no Tx byte is pending.
REQ-003 SHALL have one clock, CLK, and one reset, RSTn; reset is asynchronous and active-low.
REQ-004 CLK  input  1  system clock, all logic on posedge.
REQ-005 RSTn  input  1  asynchronous active-low reset.
REQ-006 SPI_CS  input  1  chip select from external master, active low.
REQ-007 SPI_SCK  input  1  serial clock from master, idles high (mode 3).
REQ-008 SPI_MOSI  input  1  serial data from master, MSB first.
REQ-009 SPI_MISO  output  1  serial data to master, MSB first.
REQ-010 SPI_MISO_En  output  1  MISO drive enable, high while selected.
REQ-011 Tx_Data  input  8  byte to transmit.
REQ-012 Tx_Load  input  1  one-cycle strobe writing Tx_Data into Tx buffer.
REQ-013 Tx_Ready  output  1  Tx buffer empty, may load.
REQ-014 Rx_Data  output  8  last received byte.
REQ-015 Rx_Valid  output  1  Rx_Data holds unacknowledged byte.
REQ-016 Rx_Ack  input  1  one-cycle strobe clearing Rx_Valid.
REQ-017 Rx_Overrun  output  1  sticky overrun flag (see Configuration).

Function
REQ-018 SPI_CS, SPI_SCK, SPI_MOSI SHALL pass through SYNC_STAGES flops plus one edge-detect flop; pin edge to internal action = SYNC_STAGES+1 CLK.
REQ-019 SCK high and low phases SHALL each be >= 4 CLK; faster SCK is unsupported.
REQ-020 States: IDLE (CS high), SHIFT (CS low, bit_cnt 0..7); IDLE->SHIFT on synced CS fall, SHIFT->IDLE on synced CS rise.
REQ-021 On IDLE->SHIFT, tx shift register SHALL load Tx buffer if full (buffer then empties, Tx_Ready=1), else IDLE_FILL; SPI_MISO = bit 7 same cycle.
REQ-022 On synced SCK rise in SHIFT, MOSI SHALL shift into rx register LSB, bit_cnt increments.
REQ-023 On synced SCK fall in SHIFT, tx register SHALL shift left, SPI_MISO presents next bit; after bit_cnt wraps 7->0, the fall reloads tx register per REQ-021 (back-to-back bytes).
REQ-024 On 8th rise: Rx_Data <= completed byte, Rx_Valid <= 1 next CLK, bit_cnt -> 0.
REQ-025 Rx_Ack SHALL clear Rx_Valid next CLK; byte completion same cycle as Rx_Ack wins (Rx_Valid stays 1).
REQ-026 Tx_Load with Tx_Ready=1 SHALL fill buffer, Tx_Ready=0 next CLK; Tx_Load with Tx_Ready=0 SHALL be ignored.
REQ-027 Tx_Load coinciding with a buffer consume SHALL be ignored (Tx_Ready was 0).
REQ-028 CS rise mid-byte SHALL abort: bit_cnt=0, partial Rx discarded, no Rx_Valid, Tx buffer unaffected.
REQ-029 SPI_MISO_En SHALL equal inverted synced CS; SPI_MISO = 1 in IDLE.

Reset
REQ-030 On RSTn low: state IDLE, bit_cnt 0, synchronizers to CS=1/SCK=1/MOSI=0, SPI_MISO=1, SPI_MISO_En=0, Tx_Ready=1, Rx_Data=0, Rx_Valid=0, Rx_Overrun=0.
REQ-031 Reset mid-transfer SHALL discard all shift and buffer contents; after release block waits for a fresh CS fall.

Configuration
REQ-032 Macro SPI_SLAVE_OVERRUN_EN defined: byte completion while Rx_Valid=1 (and no same-cycle Rx_Ack) SHALL set Rx_Overrun, Rx_Data overwritten; Rx_Ack clears Rx_Overrun.
REQ-033 Macro undefined: Rx_Overrun SHALL be constant 0, overwrite silent, no overrun logic.

Structure
REQ-034 Package spi_pkg SHALL hold SPI_BITS=8, default IDLE_FILL, state encoding constants.
REQ-035 Sub-module spi_input_sync (synchronizer + rise/fall detect, one bit) SHALL be instantiated for CS and SCK; MOSI uses synchronizer only.

Verification
REQ-036 Tx_Load 8'hA5, master mode 3 sends 8'h3C at CLK/8 -> master reads 8'hA5, Rx_Data=8'h3C, Rx_Valid=1.
REQ-037 No Tx_Load, one byte -> master reads 8'hFF, Tx_Ready stays 1.
REQ-038 Load 8'h11, CS low, load 8'h22 after first byte starts, 2 bytes 8'h01,8'h02 -> MISO 8'h11,8'h22; Rx 8'h01 then 8'h02.
REQ-039 CS rise after 5 bits -> Rx_Valid stays 0, next full byte 8'h5A received correctly.
REQ-040 Two bytes without Rx_Ack (macro on) -> Rx_Data=second byte, Rx_Overrun=1; Rx_Ack -> both 0; macro off -> Rx_Overrun=0.
REQ-041 RSTn low during bit 4 -> all outputs at REQ-030 values, subsequent transfer 8'hC3 correct.
